// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO read port into a registered valid/ready
// stream with a two-entry skid buffer, a pop counter and a sticky underrun flag.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   read_clk,
    input  logic                   reset,
    input  logic                   can_read,
    input  logic [DATA_WIDTH-1:0]  read_data,
    output logic                   read,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   flush,
    input  logic                   active,
    output logic [COUNT_WIDTH-1:0] words_read,
    output logic                   underrun
);

    localparam int unsigned OCC_WIDTH = 2;

    logic [OCC_WIDTH-1:0]   r_occ;
    logic [DATA_WIDTH-1:0]  r_a;
    logic [DATA_WIDTH-1:0]  r_b;
    logic [COUNT_WIDTH-1:0] r_words;
    logic                   r_underrun;

    logic w_push;
    logic w_pop;
    logic w_valid;

    // Pop decision uses only registered occupancy and FIFO/control inputs, never out_ready.
    assign w_valid = (r_occ != OCC_WIDTH'(0));
    assign w_push  = can_read & ~reset & ~flush & (r_occ != OCC_WIDTH'(2));
    assign w_pop   = w_valid & out_ready;

    assign read       = w_push;
    assign out_valid  = w_valid;
    assign out_data   = r_a;
    assign words_read = r_words;
    assign underrun   = r_underrun;

    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_occ      <= OCC_WIDTH'(0);
            r_a        <= DATA_WIDTH'(0);
            r_b        <= DATA_WIDTH'(0);
            r_words    <= COUNT_WIDTH'(0);
            r_underrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_words <= r_words + COUNT_WIDTH'(1);
            end

            if (flush) begin
                r_underrun <= 1'b0;
            end else if (active && out_ready && !w_valid) begin
                r_underrun <= 1'b1;
            end

            // A flush drops every entry left after this cycle's pop; no push can occur then.
            if (flush) begin
                r_occ <= OCC_WIDTH'(0);
            end else begin
                case (r_occ)
                    OCC_WIDTH'(0): begin
                        if (w_push) begin
                            r_a   <= read_data;
                            r_occ <= OCC_WIDTH'(1);
                        end
                    end
                    OCC_WIDTH'(1): begin
                        if (w_push && !w_pop) begin
                            r_b   <= read_data;
                            r_occ <= OCC_WIDTH'(2);
                        end else if (w_push && w_pop) begin
                            r_a <= read_data;
                        end else if (w_pop) begin
                            r_occ <= OCC_WIDTH'(0);
                        end
                    end
                    OCC_WIDTH'(2): begin
                        if (w_pop) begin
                            r_a   <= r_b;
                            r_occ <= OCC_WIDTH'(1);
                        end
                    end
                    default: r_occ <= OCC_WIDTH'(0);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue models the FIFO, a second
// queue holds words expected on the stream in order.
module tb_fifo_stream_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          reset;
    logic          can_read;
    logic [DW-1:0] read_data;
    logic          out_ready;
    logic          flush;
    logic          active;

    logic          read;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] words_read;
    logic          underrun;

    logic          read4;
    logic          out_valid4;
    logic [DW-1:0] out_data4;
    logic [3:0]    words_read4;
    logic          underrun4;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] out_log[$];
    logic [CW-1:0] m_words;
    logic          m_under;
    logic          prev_rst;

    int n_cmp;
    int n_bad;

    fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) u_dut (
        .read_clk(clk), .reset(reset), .can_read(can_read), .read_data(read_data),
        .read(read), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .active(active), .words_read(words_read), .underrun(underrun)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) u_dut4 (
        .read_clk(clk), .reset(reset), .can_read(can_read), .read_data(read_data),
        .read(read4), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .flush(flush), .active(active), .words_read(words_read4), .underrun(underrun4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: present FIFO head, check at negedge, predict the edge, pop model FIFO.
    task automatic cycle();
        logic rd_m;
        logic vld_m;
        rd_m      = 1'b0;
        can_read  = (fifo_q.size() != 0);
        read_data = can_read ? fifo_q[0] : 16'h0000;
        @(negedge clk);
        if (reset) begin
            check("rst_read", 32'(read), 32'd0);
            if (prev_rst) begin
                check("rst_valid", 32'(out_valid), 32'd0);
                check("rst_data", 32'(out_data), 32'd0);
                check("rst_words", 32'(words_read), 32'd0);
                check("rst_underrun", 32'(underrun), 32'd0);
                check("rst_words4", 32'(words_read4), 32'd0);
            end
            exp_q.delete();
            m_words = '0;
            m_under = 1'b0;
        end else begin
            vld_m = (exp_q.size() != 0);
            rd_m  = can_read && !flush && (exp_q.size() < 2);
            check("read", 32'(read), 32'(rd_m));
            check("valid", 32'(out_valid), 32'(vld_m));
            check("words", 32'(words_read), 32'(m_words));
            check("words4", 32'(words_read4), 32'(m_words[3:0]));
            check("underrun", 32'(underrun), 32'(m_under));
            if (vld_m) check("data", 32'(out_data), 32'(exp_q[0]));
            if (vld_m && out_ready) out_log.push_back(exp_q.pop_front());
            if (flush) m_under = 1'b0;
            else if (active && out_ready && !vld_m) m_under = 1'b1;
            if (flush) exp_q.delete();
            if (rd_m) begin
                exp_q.push_back(fifo_q[0]);
                m_words = m_words + CW'(1);
            end
        end
        prev_rst = reset;
        @(posedge clk);
        #1;
        if (rd_m) void'(fifo_q.pop_front());
    endtask

    initial begin
        int idx;
        logic [CW-1:0] wr_save;
        clk = 1'b0; reset = 1'b1; out_ready = 1'b1; flush = 1'b0; active = 1'b0;
        can_read = 1'b0; read_data = '0;
        n_cmp = 0; n_bad = 0; m_words = '0; m_under = 1'b0; prev_rst = 1'b1;

        // Reset held with a word waiting in the FIFO
        fifo_q.push_back(16'hdead);
        repeat (3) cycle();
        check("rst_no_pop", 32'(fifo_q.size()), 32'd1);
        reset = 1'b0;

        // Streaming
        fifo_q.push_back(16'hbeef); fifo_q.push_back(16'hfeed); fifo_q.push_back(16'hface);
        repeat (6) cycle();
        check("stream_words", 32'(words_read), 32'd4);
        check("stream_last", 32'(out_log[3]), 32'hface);

        // Backpressure
        out_ready = 1'b0;
        fifo_q.push_back(16'hdead); fifo_q.push_back(16'hbeef);
        fifo_q.push_back(16'hfeed); fifo_q.push_back(16'hface);
        repeat (4) cycle();
        check("bp_words", 32'(words_read), 32'd6);
        check("bp_hold", 32'(out_data), 32'hdead);
        idx = out_log.size();
        out_ready = 1'b1;
        repeat (6) cycle();
        check("bp_words_after", 32'(words_read), 32'd8);
        check("bp_order3", 32'(out_log[idx+3]), 32'hface);

        // Underrun
        active = 1'b1;
        repeat (3) cycle();
        check("ur_set", 32'(underrun), 32'd1);
        fifo_q.push_back(16'h1234); fifo_q.push_back(16'h5678);
        repeat (4) cycle();
        check("ur_sticky", 32'(underrun), 32'd1);
        active = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("ur_cleared", 32'(underrun), 32'd0);

        // Flush with two words buffered
        out_ready = 1'b0;
        fifo_q.push_back(16'hdead); fifo_q.push_back(16'hbeef);
        fifo_q.push_back(16'hfeed); fifo_q.push_back(16'hface);
        repeat (2) cycle();
        check("fl_pre_b", 32'(u_dut.r_b), 32'hbeef);
        wr_save = words_read;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_words", 32'(words_read), 32'(wr_save));
        check("fl_valid", 32'(out_valid), 32'd0);
        idx = out_log.size();
        out_ready = 1'b1;
        repeat (5) cycle();
        check("fl_next", 32'(out_log[idx]), 32'hfeed);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            active    = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8)
                fifo_q.push_back(DW'($urandom));
            cycle();
        end
        flush = 1'b0; active = 1'b0; out_ready = 1'b1;

        // Counter wrap on the 4-bit instance
        reset = 1'b1;
        fifo_q.delete();
        repeat (2) cycle();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) fifo_q.push_back(DW'(i + 100));
        repeat (20) cycle();
        check("wrap4", 32'(words_read4), 32'd1);
        check("wrap16", 32'(words_read), 32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
